// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB bundle with valid/ready handshake on both sides of the stage
interface mem_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic            ready_out;
  logic            reg_write_in;
  logic [1:0]      mem_reg_in;
  logic [XLEN-1:0] alu_res_in;
  logic [XLEN-1:0] next_sel_addr_in;
  logic [XLEN-1:0] wrap_load_in;
  logic [XLEN-1:0] instruction_in;
  logic [XLEN-1:0] pre_address_in;

  logic            valid_out;
  logic            ready_in;
  logic            reg_write_out;
  logic [1:0]      mem_reg_out;
  logic [XLEN-1:0] alu_res_out;
  logic [XLEN-1:0] next_sel_addr_out;
  logic [XLEN-1:0] wrap_load_out;
  logic [XLEN-1:0] instruction_out;
  logic [XLEN-1:0] pre_address_out;

  modport slave (
    input  valid_in, reg_write_in, mem_reg_in, alu_res_in, next_sel_addr_in,
           wrap_load_in, instruction_in, pre_address_in, ready_in,
    output ready_out, valid_out, reg_write_out, mem_reg_out, alu_res_out,
           next_sel_addr_out, wrap_load_out, instruction_out, pre_address_out
  );

  modport master (
    output valid_in, reg_write_in, mem_reg_in, alu_res_in, next_sel_addr_in,
           wrap_load_in, instruction_in, pre_address_in, ready_in,
    input  ready_out, valid_out, reg_write_out, mem_reg_out, alu_res_out,
           next_sel_addr_out, wrap_load_out, instruction_out, pre_address_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with valid/ready, optional skid entry, flush and retire count
module mem_wb_stage #(
  parameter int              XLEN     = 32,
  parameter int              SKID     = 1,
  parameter int              CNT_W    = 64,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_wb_stage_if.slave    bus,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      mem_reg;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] next_sel_addr;
    logic [XLEN-1:0] wrap_load;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pre_address;
  } bundle_t;

  localparam bundle_t BUBBLE = '{
    reg_write:     1'b0,
    mem_reg:       2'b00,
    alu_res:       '0,
    next_sel_addr: '0,
    wrap_load:     '0,
    instruction:   NOP_INSN,
    pre_address:   '0
  };

  typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_FULL} state_t;
  typedef enum logic [1:0] {SEL_KEEP, SEL_IN, SEL_SKID, SEL_BUBBLE} sel_t;

  state_t  state;
  state_t  state_d;
  sel_t    main_sel;
  logic    skid_load;
  logic    ready_q;
  logic    accept;
  logic    xfer;
  bundle_t main_q;
  bundle_t skid_q;
  bundle_t in_b;

  assign in_b = '{
    reg_write:     bus.reg_write_in,
    mem_reg:       bus.mem_reg_in,
    alu_res:       bus.alu_res_in,
    next_sel_addr: bus.next_sel_addr_in,
    wrap_load:     bus.wrap_load_in,
    instruction:   bus.instruction_in,
    pre_address:   bus.pre_address_in
  };

  assign bus.valid_out = (state != ST_EMPTY);
  // With a skid entry the ready is a flop so the upstream path stays short.
  assign bus.ready_out = (SKID != 0) ? ready_q : ((state == ST_EMPTY) || bus.ready_in);

  assign accept = bus.valid_in && bus.ready_out;
  assign xfer   = bus.valid_out && bus.ready_in;

  always_comb begin
    state_d   = state;
    main_sel  = SEL_KEEP;
    skid_load = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_sel = SEL_IN;
          state_d  = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (accept && xfer) begin
          main_sel = SEL_IN;
        end else if (accept && (SKID != 0)) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (xfer) begin
          main_sel = SEL_BUBBLE;
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          main_sel = SEL_SKID;
          state_d  = ST_MAIN;
        end
      end
      default: begin
        main_sel = SEL_BUBBLE;
        state_d  = ST_EMPTY;
      end
    endcase
    // A beat accepted in the flush cycle is swallowed; the handshake itself is untouched.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_sel  = SEL_BUBBLE;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      ready_q     <= 1'b1;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      retired_cnt <= '0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d != ST_FULL);
      case (main_sel)
        SEL_IN:     main_q <= in_b;
        SEL_SKID:   main_q <= skid_q;
        SEL_BUBBLE: main_q <= BUBBLE;
        default:    main_q <= main_q;
      endcase
      if (skid_load) begin
        skid_q <= in_b;
      end
      if (xfer) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.reg_write_out     = main_q.reg_write;
  assign bus.mem_reg_out       = main_q.mem_reg;
  assign bus.alu_res_out       = main_q.alu_res;
  assign bus.next_sel_addr_out = main_q.next_sel_addr;
  assign bus.wrap_load_out     = main_q.wrap_load;
  assign bus.instruction_out   = main_q.instruction;
  assign bus.pre_address_out   = main_q.pre_address;

endmodule
